// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared helpers for the round-robin arbiter.
//   clog2_min1 : index width for a requester count (never below 1 bit)
//   next_prio  : rotated priority after a grant (wraps to 0 after the last requester)
//   beat_lsb   : bit offset of a requester's beat inside the packed data bus
package arbiter_pkg;

  localparam int NUM_MAX = 16;

  function automatic int clog2_min1(input int n);
    int w;
    if (n > 32'sd1) begin
      w = $clog2(n);
    end else begin
      w = 32'sd1;
    end
    return w;
  endfunction

  function automatic int next_prio(input int g, input int num);
    int p;
    if (g == num - 32'sd1) begin
      p = 32'sd0;
    end else begin
      p = g + 32'sd1;
    end
    return p;
  endfunction

  function automatic int beat_lsb(input int idx, input int din);
    return idx * din;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc: combinational rotating-priority encoder.
//   req         : request vector, one bit per requester
//   prio        : index that currently has highest priority
//   grant_idx   : first requester at or after prio (wrapping) with req set
//   grant_valid : high when any request is present
module rr_prio_enc
  import arbiter_pkg::*;
#(
  parameter int NUM  = 4,
  parameter int IDXW = clog2_min1(NUM)
) (
  input  logic [NUM-1:0]  req,
  input  logic [IDXW-1:0] prio,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  logic [2*NUM-1:0] req_rot_s;

  // Doubling the request vector and shifting by prio puts the search order in bit order.
  always_comb begin
    req_rot_s = {req, req} >> prio;
  end

  // Take the lowest set bit of the rotated vector and map it back to a requester index.
  always_comb begin
    int hit;
    hit         = 32'sd0;
    grant_valid = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      if (!grant_valid && req_rot_s[k]) begin
        grant_valid = 1'b1;
        hit         = k;
      end else begin
        hit         = hit;
      end
    end
    grant_idx = IDXW'((int'(prio) + hit) % NUM);
  end

endmodule

// File: rtl/arbiter_rr.sv
// arbiter_rr: NUM-input round-robin arbiter feeding one registered valid/ready stage.
// Optional feature: define ARB_PKT_LOCK_EN to hold the grant on one requester until
// it sends a beat whose data MSB (eot) is set.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   din_valid  : per-requester valid
//   din_ready  : per-requester ready, one-hot or zero
//   din_data   : requester i at bits [i*DIN +: DIN]
//   dout_valid : output stage holds a beat
//   dout_ready : downstream accepts
//   dout_data  : {index, data}, index in the MSBs
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int NUM = 4,
  parameter int DIN = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM-1:0]                    din_valid,
  output logic [NUM-1:0]                    din_ready,
  input  logic [NUM*DIN-1:0]                din_data,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic [DIN+clog2_min1(NUM)-1:0]    dout_data
);

  localparam int IDXW = clog2_min1(NUM);
  localparam int OUTW = DIN + IDXW;

  logic [IDXW-1:0] prio_q, prio_d;
  logic            out_valid_q, out_valid_d;
  logic [OUTW-1:0] out_data_q, out_data_d;
`ifdef ARB_PKT_LOCK_EN
  logic            lock_q, lock_d;
  logic [IDXW-1:0] lock_idx_q, lock_idx_d;
`endif

  logic [NUM-1:0]  req_s;
  logic [IDXW-1:0] grant_idx_s;
  logic            grant_valid_s;
  logic            accept_s;
  logic [DIN-1:0]  grant_data_s;

  // Restrict eligible requesters to the locked one while a packet is in flight.
  always_comb begin
    req_s = din_valid;
`ifdef ARB_PKT_LOCK_EN
    if (lock_q) begin
      for (int k = 0; k < NUM; k++) begin
        if (lock_idx_q == IDXW'(k)) begin
          req_s[k] = din_valid[k];
        end else begin
          req_s[k] = 1'b0;
        end
      end
    end else begin
      req_s = din_valid;
    end
`endif
  end

  rr_prio_enc #(
    .NUM  (NUM),
    .IDXW (IDXW)
  ) u_enc (
    .req         (req_s),
    .prio        (prio_q),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // The stage can take a beat when empty or draining this cycle; held off while in reset.
  assign accept_s = rst & grant_valid_s & (~out_valid_q | dout_ready);

  // Select the granted beat and raise only that requester's ready.
  always_comb begin
    grant_data_s = {DIN{1'b0}};
    din_ready    = {NUM{1'b0}};
    for (int k = 0; k < NUM; k++) begin
      if (grant_idx_s == IDXW'(k)) begin
        grant_data_s = din_data[beat_lsb(k, DIN) +: DIN];
        din_ready[k] = accept_s;
      end else begin
        din_ready[k] = 1'b0;
      end
    end
  end

  // Next state: load on accept (which also covers a simultaneous drain), else clear on drain.
  always_comb begin
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef ARB_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
`endif
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = {grant_idx_s, grant_data_s};
`ifdef ARB_PKT_LOCK_EN
      // eot=0 keeps the grant on this requester and freezes rotation.
      if (grant_data_s[DIN-1]) begin
        lock_d = 1'b0;
        prio_d = IDXW'(next_prio(int'(grant_idx_s), NUM));
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = grant_idx_s;
      end
`else
      prio_d = IDXW'(next_prio(int'(grant_idx_s), NUM));
`endif
    end else if (dout_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Arbitration pointer, output stage and packet lock registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q      <= {IDXW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {OUTW{1'b0}};
`ifdef ARB_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= {IDXW{1'b0}};
`endif
    end else begin
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef ARB_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign dout_valid = out_valid_q;
  assign dout_data  = out_data_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// tb_arbiter_rr: directed vector table, hand-written reset/lock sequences and a
// randomized phase checked against a queue-based round-robin model.
module tb_arbiter_rr;

  localparam int NUM = 4;
  localparam int DIN = 16;

  logic              clk;
  logic              rst;
  logic [NUM-1:0]    din_valid;
  logic [NUM-1:0]    din_ready;
  logic [NUM*DIN-1:0] din_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [DIN+1:0]    dout_data;

  int checks   = 0;
  int failures = 0;

  arbiter_rr #(.NUM(NUM), .DIN(DIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, check ready before the edge and the output stage after it.
  task automatic step(input string tag, input logic [3:0] v, input logic dr,
                      input logic [3:0] er, input logic edv, input logic [1:0] eidx);
    logic [17:0] ed;
    din_valid  = v;
    dout_ready = dr;
    #1;
    chk({tag, ".rdy"}, 32'(din_ready), 32'(er));
    ed = {eidx, din_data[int'(eidx)*16 +: 16]};
    @(posedge clk);
    #1;
    chk({tag, ".dv"}, 32'(dout_valid), 32'(edv));
    if (edv) chk({tag, ".data"}, 32'(dout_data), 32'(ed));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic std_data();
    for (int i = 0; i < NUM; i++) din_data[i*16 +: 16] = 16'h8000 + 16'(i) * 16'h0101;
  endtask

  // ---------------- reference model ----------------
  // Priority order kept as a queue: the head is tried first; a granted requester
  // and everything ahead of it move to the back.
  int          m_order[$];
  bit          m_ov;
  logic [17:0] m_od;
  bit          m_lock;
  int          m_lidx;
  logic [3:0]  last_rdy;

  task automatic m_reset();
    m_order = {0, 1, 2, 3};
    m_ov    = 1'b0;
    m_od    = 18'h0;
    m_lock  = 1'b0;
    m_lidx  = 0;
  endtask

  function automatic int m_grant(input logic [3:0] v);
    int g;
    g = -1;
`ifdef ARB_PKT_LOCK_EN
    if (m_lock) begin
      if (v[m_lidx]) g = m_lidx;
      return g;
    end
`endif
    foreach (m_order[j]) if (g < 0 && v[m_order[j]]) g = m_order[j];
    return g;
  endfunction

  task automatic m_rotate(input int g);
    for (int n = 0; n < NUM; n++) begin
      int x;
      x = m_order.pop_front();
      m_order.push_back(x);
      if (x == g) break;
    end
  endtask

  task automatic m_clock(input int g, input bit acc);
    logic [15:0] d;
    if (acc) begin
      d    = din_data[g*16 +: 16];
      m_ov = 1'b1;
      m_od = {g[1:0], d};
`ifdef ARB_PKT_LOCK_EN
      if (!d[15]) begin
        m_lock = 1'b1;
        m_lidx = g;
      end else begin
        m_lock = 1'b0;
        m_rotate(g);
      end
`else
      m_rotate(g);
`endif
    end else if (dout_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic tick(input string tag);
    int g;
    logic [3:0] er;
    #1;
    g  = m_grant(din_valid);
    er = 4'b0000;
    if (g >= 0 && (!m_ov || dout_ready)) er[g] = 1'b1;
    chk({tag, ".rdy"}, 32'(din_ready), 32'(er));
    last_rdy = din_ready;
    @(posedge clk);
    m_clock(g, er != 4'b0000);
    #1;
    chk({tag, ".dv"}, 32'(dout_valid), 32'(m_ov));
    if (m_ov) chk({tag, ".data"}, 32'(dout_data), 32'(m_od));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0] v;
    logic       dr;
    logic [3:0] rdy;
    logic       dv;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[10] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[15] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3};
    tbl[16] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[17] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[18] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};

    // Reset held with every requester asserting valid.
    rst        = 1'b0;
    din_valid  = 4'b1111;
    dout_ready = 1'b1;
    std_data();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.dv", 32'(dout_valid), 32'h0);
    chk("reset.data", 32'(dout_data), 32'h0);
    chk("reset.rdy", 32'(din_ready), 32'h0);
    #2;
    rst = 1'b1;

    // Contention, backpressure, sparse and bubble patterns.
    for (int r = 0; r < 19; r++) begin
      step($sformatf("tbl%0d", r), tbl[r].v, tbl[r].dr, tbl[r].rdy, tbl[r].dv, tbl[r].idx);
    end

    // Asynchronous reset while a beat (an open packet when locking is built) is held.
    din_data[1*16 +: 16] = 16'h0055;
    step("arst.pre", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
    dout_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst.dv", 32'(dout_valid), 32'h0);
    chk("arst.data", 32'(dout_data), 32'h0);
    chk("arst.rdy", 32'(din_ready), 32'h0);
    std_data();
    #2;
    rst = 1'b1;
    step("arst.post0", 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    step("arst.post1", 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);

`ifdef ARB_PKT_LOCK_EN
    // req0 sends a 3-beat packet with a gap; req1 waits throughout.
    do_reset();
    std_data();
    din_data[0 +: 16] = 16'h0000;
    step("lock.b0", 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0);
    step("lock.gap", 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0);
    din_data[0 +: 16] = 16'h0001;
    step("lock.b1", 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0);
    din_data[0 +: 16] = 16'h8002;
    step("lock.b2", 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0);
    step("lock.r1", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    m_reset();
    din_valid = 4'b0000;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM; i++) begin
        if (!din_valid[i] && $urandom_range(0, 2) == 0) begin
          din_valid[i]        = 1'b1;
          din_data[i*16 +: 16] = 16'($urandom);
        end
      end
      dout_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
      din_valid = din_valid & ~last_rdy;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
